// File: rtl/tiled_matmul_scheduler_pkg.sv
// Shared types for the tiled matrix-multiply scheduler.
//   sched_st_t : tile sequencer FSM states
//   tile_cfg_t : per-tile geometry presented to the address generator
//   clip_min   : edge-clipped tile extent, min(tile, dim - idx)
package tmm_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned IDX_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } sched_st_t;

  typedef struct packed {
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic [ADDR_W-1:0] base_c;
    logic [IDX_W-1:0]  e_tm;
    logic [IDX_W-1:0]  e_tn;
    logic [IDX_W-1:0]  e_tk;
    logic              first_k;
    logic              last_k;
  } tile_cfg_t;

  // idx is always below dim while a job runs, so dim - idx never underflows.
  function automatic logic [IDX_W-1:0] clip_min(input logic [IDX_W-1:0] tile,
                                                input logic [IDX_W-1:0] dim,
                                                input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] rem;
    rem = dim - idx;
    return (tile < rem) ? tile : rem;
  endfunction

endpackage

// File: rtl/tiled_matmul_scheduler_if.sv
// Scheduler <-> tile address generator link.
//   master (scheduler): drives start_tile, tile bases, effective sizes,
//                       row strides, first_k/last_k; receives ready/done.
//   slave  (AGU)      : the mirror image.
interface tiled_matmul_scheduler_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 8
);
  logic                  start_tile;
  logic [ADDR_WIDTH-1:0] baseA_tile;
  logic [ADDR_WIDTH-1:0] baseB_tile;
  logic [ADDR_WIDTH-1:0] baseC_tile;
  logic [IDX_WIDTH-1:0]  eTM;
  logic [IDX_WIDTH-1:0]  eTN;
  logic [IDX_WIDTH-1:0]  eTK;
  logic [IDX_WIDTH-1:0]  FULL_K;
  logic [IDX_WIDTH-1:0]  FULL_N;
  logic                  first_k;
  logic                  last_k;
  logic                  agu_tile_ready;
  logic                  agu_tile_done;

  modport master (
    output start_tile, baseA_tile, baseB_tile, baseC_tile,
           eTM, eTN, eTK, FULL_K, FULL_N, first_k, last_k,
    input  agu_tile_ready, agu_tile_done
  );

  modport slave (
    input  start_tile, baseA_tile, baseB_tile, baseC_tile,
           eTM, eTN, eTK, FULL_K, FULL_N, first_k, last_k,
    output agu_tile_ready, agu_tile_done
  );
endinterface

// File: rtl/tiled_matmul_scheduler_geom.sv
// tile_geom_calc: registered tile base-address and edge-clip computation.
//   load            : capture geometry for the current (m0,k0,n0) indices
//   m0/n0/k0        : current tile origin
//   m/n/k_dim, tm/tn/tk : job dimensions and nominal tile sizes
//   base_a/b/c      : matrix base addresses
//   tile            : registered tile_cfg_t, held until the next load
module tile_geom_calc
  import tmm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [IDX_W-1:0]  m0,
  input  logic [IDX_W-1:0]  n0,
  input  logic [IDX_W-1:0]  k0,
  input  logic [IDX_W-1:0]  m_dim,
  input  logic [IDX_W-1:0]  n_dim,
  input  logic [IDX_W-1:0]  k_dim,
  input  logic [IDX_W-1:0]  tm,
  input  logic [IDX_W-1:0]  tn,
  input  logic [IDX_W-1:0]  tk,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  output tile_cfg_t         tile
);

  logic [2*IDX_W-1:0] prod_a, prod_b, prod_c;
  logic [IDX_W:0]     k_end;

  assign prod_a = m0 * k_dim;
  assign prod_b = k0 * n_dim;
  assign prod_c = m0 * n_dim;
  assign k_end  = {1'b0, k0} + {1'b0, tk};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile <= '0;
    end else if (load) begin
      tile.base_a  <= base_a + ADDR_W'(prod_a) + ADDR_W'(k0);
      tile.base_b  <= base_b + ADDR_W'(prod_b) + ADDR_W'(n0);
      tile.base_c  <= base_c + ADDR_W'(prod_c) + ADDR_W'(n0);
      tile.e_tm    <= clip_min(tm, m_dim, m0);
      tile.e_tn    <= clip_min(tn, n_dim, n0);
      tile.e_tk    <= clip_min(tk, k_dim, k0);
      tile.first_k <= (k0 == '0);
      tile.last_k  <= (k_end >= {1'b0, k_dim});
    end
  end

endmodule

// File: rtl/tiled_matmul_scheduler.sv
// tiled_matmul_scheduler: walks C[MxN] = A[MxK]*B[KxN] tile by tile
// (m outer, k middle, n inner) and launches the address generator per tile.
//   clk, rst_n        : clock, async active-low reset
//   start, abort      : job launch pulse / synchronous job abort
//   M/N/K_dim, T*_cfg : job dimensions and tile sizes (sampled on start)
//   baseA/B/C         : matrix bases (sampled on start)
//   agu               : link to the tile address generator (master side)
//   busy, done, err   : job status; tile_count counts completed tiles
module tiled_matmul_scheduler
  import tmm_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W,
  parameter int unsigned IDX_WIDTH  = IDX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [IDX_WIDTH-1:0]  M_dim,
  input  logic [IDX_WIDTH-1:0]  N_dim,
  input  logic [IDX_WIDTH-1:0]  K_dim,
  input  logic [IDX_WIDTH-1:0]  TM_cfg,
  input  logic [IDX_WIDTH-1:0]  TN_cfg,
  input  logic [IDX_WIDTH-1:0]  TK_cfg,
  input  logic [ADDR_WIDTH-1:0] baseA,
  input  logic [ADDR_WIDTH-1:0] baseB,
  input  logic [ADDR_WIDTH-1:0] baseC,
  tiled_matmul_scheduler_if.master agu,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           tile_count
);

  sched_st_t st_q, st_d;

  logic [IDX_WIDTH-1:0]  m_q, n_q, k_q, tm_q, tn_q, tk_q;
  logic [IDX_WIDTH-1:0]  m0_q, n0_q, k0_q;
  logic [ADDR_WIDTH-1:0] ba_q, bb_q, bc_q;
  logic                  start_tile_q, start_tile_d;
  logic                  done_q, done_d, err_q, err_d, busy_q;
  logic [15:0]           tile_cnt_q;
  logic                  cfg_ok, accept, abort_now, tile_done;
  logic                  n_wrap, k_wrap, m_wrap;
  logic [IDX_WIDTH:0]    n_sum, k_sum, m_sum;
  tile_cfg_t             tile;

  assign cfg_ok    = (|M_dim) && (|N_dim) && (|K_dim) &&
                     (|TM_cfg) && (|TN_cfg) && (|TK_cfg);
  assign accept    = (st_q == ST_IDLE) && start && cfg_ok;
  assign abort_now = abort && (st_q != ST_IDLE);
  assign tile_done = (st_q == ST_WAIT) && agu.agu_tile_done && !abort;

  assign n_sum  = {1'b0, n0_q} + {1'b0, tn_q};
  assign k_sum  = {1'b0, k0_q} + {1'b0, tk_q};
  assign m_sum  = {1'b0, m0_q} + {1'b0, tm_q};
  assign n_wrap = (n_sum >= {1'b0, n_q});
  assign k_wrap = (k_sum >= {1'b0, k_q});
  assign m_wrap = (m_sum >= {1'b0, m_q});

  // start_tile is a registered output, so the launch is decided from the
  // ready level seen one cycle earlier (SETUP, or an ISSUE cycle without a
  // launch); ISSUE is left in the cycle the pulse is actually driven.
  always_comb begin
    st_d         = st_q;
    start_tile_d = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_ok) st_d = ST_SETUP;
          else        err_d = 1'b1;
        end
      end
      ST_SETUP: begin
        start_tile_d = agu.agu_tile_ready;
        st_d         = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (start_tile_q) st_d = ST_WAIT;
        else              start_tile_d = agu.agu_tile_ready;
      end
      ST_WAIT: begin
        if (agu.agu_tile_done) st_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (n_wrap && k_wrap && m_wrap) begin
          st_d   = ST_DONE;
          done_d = 1'b1;
        end else begin
          st_d = ST_SETUP;
        end
      end
      ST_DONE: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
    if (abort_now) begin
      st_d         = ST_IDLE;
      start_tile_d = 1'b0;
      done_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= ST_IDLE;
      start_tile_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      tile_cnt_q   <= '0;
    end else begin
      st_q         <= st_d;
      start_tile_q <= start_tile_d;
      done_q       <= done_d;
      err_q        <= err_d;
      if (accept)                          busy_q <= 1'b1;
      else if (abort_now || st_q == ST_DONE) busy_q <= 1'b0;
      if (accept)         tile_cnt_q <= '0;
      else if (tile_done) tile_cnt_q <= tile_cnt_q + 16'd1;
    end
  end

  // Config is captured only for a legal start so a rejected start leaves
  // the previous job's strides visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {m_q, n_q, k_q, tm_q, tn_q, tk_q} <= '0;
      {ba_q, bb_q, bc_q}                <= '0;
      {m0_q, n0_q, k0_q}                <= '0;
    end else if (accept) begin
      m_q  <= M_dim;  n_q  <= N_dim;  k_q  <= K_dim;
      tm_q <= TM_cfg; tn_q <= TN_cfg; tk_q <= TK_cfg;
      ba_q <= baseA;  bb_q <= baseB;  bc_q <= baseC;
      {m0_q, n0_q, k0_q} <= '0;
    end else if (st_q == ST_NEXT && !abort) begin
      if (!n_wrap) begin
        n0_q <= n_sum[IDX_WIDTH-1:0];
      end else begin
        n0_q <= '0;
        if (!k_wrap) begin
          k0_q <= k_sum[IDX_WIDTH-1:0];
        end else begin
          k0_q <= '0;
          m0_q <= m_wrap ? '0 : m_sum[IDX_WIDTH-1:0];
        end
      end
    end
  end

  tile_geom_calc u_geom (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (st_q == ST_SETUP),
    .m0     (m0_q),
    .n0     (n0_q),
    .k0     (k0_q),
    .m_dim  (m_q),
    .n_dim  (n_q),
    .k_dim  (k_q),
    .tm     (tm_q),
    .tn     (tn_q),
    .tk     (tk_q),
    .base_a (ba_q),
    .base_b (bb_q),
    .base_c (bc_q),
    .tile   (tile)
  );

  assign agu.start_tile = start_tile_q;
  assign agu.baseA_tile = tile.base_a;
  assign agu.baseB_tile = tile.base_b;
  assign agu.baseC_tile = tile.base_c;
  assign agu.eTM        = tile.e_tm;
  assign agu.eTN        = tile.e_tn;
  assign agu.eTK        = tile.e_tk;
  assign agu.first_k    = tile.first_k;
  assign agu.last_k     = tile.last_k;
  assign agu.FULL_K     = k_q;
  assign agu.FULL_N     = n_q;

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign tile_count = tile_cnt_q;

endmodule

// File: tb/tb_tiled_matmul_scheduler.sv
// Bench for tiled_matmul_scheduler: a loop-nest reference model produces
// the expected tile sequence; an AGU model with random latencies drives
// ready/done and every presented tile is compared against the model.
module tb_tiled_matmul_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  M_dim = '0, N_dim = '0, K_dim = '0;
  logic [7:0]  TM_cfg = '0, TN_cfg = '0, TK_cfg = '0;
  logic [31:0] baseA = '0, baseB = '0, baseC = '0;
  logic        busy, done, err;
  logic [15:0] tile_count;

  int n_checks = 0;
  int n_fail   = 0;

  tiled_matmul_scheduler_if #(.ADDR_WIDTH(32), .IDX_WIDTH(8)) agu_bus ();

  tiled_matmul_scheduler #(.ADDR_WIDTH(32), .IDX_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .M_dim      (M_dim),
    .N_dim      (N_dim),
    .K_dim      (K_dim),
    .TM_cfg     (TM_cfg),
    .TN_cfg     (TN_cfg),
    .TK_cfg     (TK_cfg),
    .baseA      (baseA),
    .baseB      (baseB),
    .baseC      (baseC),
    .agu        (agu_bus),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .tile_count (tile_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ba, bb, bc;
    int          etm, etn, etk;
    bit          fk, lk;
  } tile_t;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic run_job(input int M, input int N, input int K,
                         input int TM, input int TN, input int TK,
                         input logic [31:0] bA, input logic [31:0] bB,
                         input logic [31:0] bC,
                         input int abort_tile, input int stall_tile, input bit poke);
    tile_t q[$];
    tile_t t;
    int    cyc, hold, d;
    bit    seen;
    for (int m = 0; m < M; m += TM)
      for (int k = 0; k < K; k += TK)
        for (int n = 0; n < N; n += TN) begin
          t.ba  = bA + 32'(m * K + k);
          t.bb  = bB + 32'(k * N + n);
          t.bc  = bC + 32'(m * N + n);
          t.etm = (TM < M - m) ? TM : M - m;
          t.etn = (TN < N - n) ? TN : N - n;
          t.etk = (TK < K - k) ? TK : K - k;
          t.fk  = (k == 0);
          t.lk  = (k + TK >= K);
          q.push_back(t);
        end

    @(negedge clk);
    M_dim = 8'(M); N_dim = 8'(N); K_dim = 8'(K);
    TM_cfg = 8'(TM); TN_cfg = 8'(TN); TK_cfg = 8'(TK);
    baseA = bA; baseB = bB; baseC = bC;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_rise", busy, 1);
    check_eq("full_k", agu_bus.FULL_K, K);
    check_eq("full_n", agu_bus.FULL_N, N);

    for (int i = 0; i < q.size(); i++) begin
      hold = (i == stall_tile) ? 10 : int'($urandom_range(0, 2));
      agu_bus.agu_tile_ready = (hold == 0);
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < 200) begin
        if (agu_bus.start_tile) begin
          seen = 1'b1;
        end else begin
          if (i == stall_tile && cyc >= 2)
            check_eq("stall_hold", agu_bus.baseC_tile, q[i].bc);
          @(negedge clk);
          cyc++;
          if (hold > 0) hold--;
          agu_bus.agu_tile_ready = (hold == 0);
        end
      end
      if (!seen) begin
        check_eq("start_tile_timeout", 0, 1);
        return;
      end
      if (i == stall_tile) check_eq("stall_wait", (cyc > 10), 1);
      check_eq("baseA_tile", agu_bus.baseA_tile, q[i].ba);
      check_eq("baseB_tile", agu_bus.baseB_tile, q[i].bb);
      check_eq("baseC_tile", agu_bus.baseC_tile, q[i].bc);
      check_eq("eTM", agu_bus.eTM, q[i].etm);
      check_eq("eTN", agu_bus.eTN, q[i].etn);
      check_eq("eTK", agu_bus.eTK, q[i].etk);
      check_eq("first_k", agu_bus.first_k, q[i].fk);
      check_eq("last_k", agu_bus.last_k, q[i].lk);
      check_eq("count_before", tile_count, i);

      agu_bus.agu_tile_ready = 1'b0;
      if (poke && i == 1) begin
        M_dim = 8'd1; N_dim = 8'd1; K_dim = 8'd1;
        start = 1'b1;
      end
      d = int'($urandom_range(1, 4));
      for (int j = 0; j < d; j++) begin
        @(negedge clk);
        start = 1'b0;
        check_eq("start_once", agu_bus.start_tile, 0);
      end

      if (i == abort_tile) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_busy", busy, 0);
        repeat (5) begin
          @(negedge clk);
          check_eq("abort_no_done", done, 0);
          check_eq("abort_no_start", agu_bus.start_tile, 0);
        end
        check_eq("abort_count", tile_count, i);
        return;
      end

      check_eq("hold_baseB", agu_bus.baseB_tile, q[i].bb);
      check_eq("hold_eTK", agu_bus.eTK, q[i].etk);
      agu_bus.agu_tile_done = 1'b1;
      @(negedge clk);
      agu_bus.agu_tile_done = 1'b0;
      check_eq("tile_count", tile_count, i + 1);
      check_eq("done_early", done, 0);
    end

    @(negedge clk);
    check_eq("done_pulse", done, 1);
    check_eq("busy_at_done", busy, 1);
    @(negedge clk);
    check_eq("done_clear", done, 0);
    check_eq("busy_fall", busy, 0);
    check_eq("final_count", tile_count, q.size());
    check_eq("final_full_k", agu_bus.FULL_K, K);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int M, N, K, cyc;
    agu_bus.agu_tile_ready = 1'b1;
    agu_bus.agu_tile_done  = 1'b0;

    #2;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_start_tile", agu_bus.start_tile, 0);
    check_eq("rst_baseA", agu_bus.baseA_tile, 0);
    check_eq("rst_eTM", agu_bus.eTM, 0);
    check_eq("rst_count", tile_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reference 8x8x8 job with a start attempt while busy.
    run_job(8, 8, 8, 4, 4, 4, 32'd0, 32'd100, 32'd200, -1, -1, 1'b1);
    // Edge-clipped job with a long ready stall on the second tile.
    run_job(6, 5, 3, 4, 4, 4, $urandom, $urandom, $urandom, -1, 1, 1'b0);

    // Illegal configuration.
    @(negedge clk);
    M_dim = 8'd4; N_dim = 8'd4; K_dim = 8'd0;
    TM_cfg = 8'd2; TN_cfg = 8'd2; TK_cfg = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("err_pulse", err, 1);
    check_eq("err_busy", busy, 0);
    @(negedge clk);
    check_eq("err_clear", err, 0);
    repeat (5) begin
      @(negedge clk);
      check_eq("err_no_start", agu_bus.start_tile, 0);
      check_eq("err_no_busy", busy, 0);
    end

    // Abort in WAIT of the third tile, then a full job.
    run_job(8, 8, 8, 4, 4, 4, 32'd0, 32'd100, 32'd200, 2, -1, 1'b0);
    run_job(8, 8, 8, 4, 4, 4, 32'd0, 32'd100, 32'd200, -1, -1, 1'b0);

    // Randomized jobs; tile sizes may exceed the dimension.
    for (int r = 0; r < 6; r++) begin
      M = int'($urandom_range(1, 12));
      N = int'($urandom_range(1, 12));
      K = int'($urandom_range(1, 12));
      run_job(M, N, K, int'($urandom_range(3, 10)), int'($urandom_range(3, 10)),
              int'($urandom_range(3, 10)), $urandom, $urandom, $urandom,
              -1, int'($urandom_range(0, 3)), 1'b0);
    end

    // Asynchronous reset in the middle of WAIT.
    @(negedge clk);
    M_dim = 8'd8; N_dim = 8'd8; K_dim = 8'd8;
    TM_cfg = 8'd4; TN_cfg = 8'd4; TK_cfg = 8'd4;
    baseA = 32'd0; baseB = 32'd100; baseC = 32'd200;
    agu_bus.agu_tile_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!agu_bus.start_tile && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("rst_test_launch", agu_bus.start_tile, 1);
    agu_bus.agu_tile_ready = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_start_tile", agu_bus.start_tile, 0);
    check_eq("arst_baseB", agu_bus.baseB_tile, 0);
    check_eq("arst_baseC", agu_bus.baseC_tile, 0);
    check_eq("arst_eTK", agu_bus.eTK, 0);
    check_eq("arst_full_n", agu_bus.FULL_N, 0);
    check_eq("arst_first_k", agu_bus.first_k, 0);
    check_eq("arst_count", tile_count, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_rst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
